// File: rtl/mem_fifo_loader.sv
// Burst loader: one fill pulse reads NUM_FIFOS*DEPTH bytes from memory and writes them
// one-hot into the FIFO bank. Optional read timeout enabled by `define LOADER_TIMEOUT_EN.
module mem_fifo_loader #(
    parameter int unsigned NUM_FIFOS  = 9,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TO_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  mode,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic [NUM_FIFOS-1:0]  fifo_full,
    output logic [DATA_WIDTH-1:0] dataByte,
    output logic [NUM_FIFOS-1:0]  fifoEnable,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TOTAL = NUM_FIFOS * DEPTH;
    localparam int unsigned KW    = (TOTAL > 1)     ? $clog2(TOTAL)     : 1;
    localparam int unsigned SW    = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam int unsigned DW    = (DEPTH > 1)     ? $clog2(DEPTH)     : 1;

    if (NUM_FIFOS < 1 || DEPTH < 1 || TO_CYCLES < 2) begin : g_param_check
        $error("mem_fifo_loader: NUM_FIFOS, DEPTH must be >=1 and TO_CYCLES >=2");
    end

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  mode_q, mode_d;
    logic [KW-1:0]         k_q, k_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [DW-1:0]         slot_q, slot_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TO_CYCLES);
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            sel_q   <= '0;
            slot_q  <= '0;
            data_q  <= '0;
`ifdef LOADER_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
`ifdef LOADER_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        mode_d     = mode_q;
        k_d        = k_q;
        sel_d      = sel_q;
        slot_d     = slot_q;
        data_d     = data_q;
        mem_rd_req = 1'b0;
        fifoEnable = '0;
        done       = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        to_d       = to_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fill) begin
                    base_d  = addr;
                    mode_d  = mode;
                    k_d     = '0;
                    sel_d   = '0;
                    slot_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_rd_req = 1'b1;
                state_d    = S_WAIT;
`ifdef LOADER_TIMEOUT_EN
                // counts cycles since the request, so expiry lands TO_CYCLES after it
                to_d       = TW'(1);
`endif
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    data_d  = mem_rd_data;
                    state_d = S_WRITE;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (to_q >= TW'(TO_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
`endif
            end
            S_WRITE: begin
                if (!fifo_full[sel_q]) begin
                    fifoEnable = NUM_FIFOS'(1) << sel_q;
                    if (k_q == KW'(TOTAL - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_REQ;
                        // row-major advances the FIFO once per DEPTH bytes; interleave every byte
                        if (mode_q) begin
                            sel_d = (sel_q == SW'(NUM_FIFOS - 1)) ? '0 : sel_q + SW'(1);
                        end else if (slot_q == DW'(DEPTH - 1)) begin
                            slot_d = '0;
                            sel_d  = sel_q + SW'(1);
                        end else begin
                            slot_d = slot_q + DW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr = base_q + ADDR_WIDTH'(k_q);
    assign dataByte = data_q;
    assign busy     = (state_q != S_IDLE);

`ifdef LOADER_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Self-checking bench for mem_fifo_loader: queue-based reference of the expected byte/FIFO
// stream, latency-programmable memory responder, and a per-cycle compare process.
module tb_mem_fifo_loader;

    localparam int unsigned NF  = 9;
    localparam int unsigned DP  = 8;
    localparam int unsigned TOT = NF * DP;
    localparam int unsigned TO  = 64;

    logic          clk, rst_n, fill, mode, mem_rd_req, mem_rd_valid;
    logic [31:0]   addr, mem_addr;
    logic [7:0]    mem_rd_data, dataByte;
    logic [NF-1:0] fifo_full, fifoEnable;
    logic          busy, done, err;

    mem_fifo_loader dut (
        .clk(clk), .rst_n(rst_n), .fill(fill), .addr(addr), .mode(mode),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .fifo_full(fifo_full), .dataByte(dataByte),
        .fifoEnable(fifoEnable), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int unsigned fifo; logic [7:0] d; } exp_t;
    typedef struct { logic [NF-1:0] en; logic [7:0] d; int unsigned cyc; } wr_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    wr_t         log_q[$];

    int unsigned n_cmp = 0, n_err = 0;
    int unsigned cyc = 0, req_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int unsigned req_cyc = 0, done_cyc = 0;
    bit          rand_lat = 0, never = 0, rand_full = 0, allow_abort = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory: byte[a] = a[7:0], latency 1 or random 1..5, or never answers
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_rd_req && !never) begin
                automatic logic [7:0] b = mem_addr[7:0];
                automatic int unsigned l = rand_lat ? $urandom_range(1, 5) : 1;
                repeat (l) @(posedge clk);
                #1 mem_rd_valid = 1'b1; mem_rd_data = b;
                @(posedge clk);
                #1 mem_rd_valid = 1'b0; mem_rd_data = 8'hxx;
            end
        end
    end

    always begin
        @(posedge clk);
        #2 if (rand_full) fifo_full = NF'($urandom & $urandom);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req", mem_rd_req, 0);
            chk("rst_en", fifoEnable, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else begin
            chk("onehot", ($countones(fifoEnable) <= 1), 1);
            if (mem_rd_req) begin
                req_cnt++;
                req_cyc = cyc;
                if (exp_addr_q.size() == 0) chk("req_expected", 0, 1);
                else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (fifoEnable != '0) begin
                wr_cnt++;
                log_q.push_back('{fifoEnable, dataByte, cyc});
                chk("write_to_full", |(fifoEnable & fifo_full), 0);
                if (exp_q.size() == 0) chk("write_expected", 0, 1);
                else begin
                    automatic exp_t e = exp_q.pop_front();
                    chk("fifo_sel", fifoEnable, NF'(1) << e.fifo);
                    chk("data", dataByte, e.d);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy", busy, 1);
                if (!allow_abort) chk("done_all_written", exp_q.size(), 0);
            end
        end
    end

    task automatic start_load(input logic [31:0] b, input logic m);
        for (int unsigned k = 0; k < TOT; k++) begin
            automatic logic [31:0] a = b + k;
            exp_addr_q.push_back(a);
            exp_q.push_back('{(m ? k % NF : k / DP), a[7:0]});
        end
        fill = 1'b1; addr = b; mode = m;
        @(posedge clk);
        #1 fill = 1'b0; addr = 32'hDEAD_BEEF; mode = ~m;
    endtask

    task automatic wait_done(input int unsigned d0, input int unsigned limit);
        int unsigned i = 0;
        while (done_cnt == d0 && i < limit) begin
            @(posedge clk);
            i++;
        end
        #1 chk("done_seen", (done_cnt != d0), 1);
    endtask

    task automatic finish_checks(input int unsigned w0, input int unsigned d0);
        chk("write_count", wr_cnt - w0, TOT);
        chk("busy_after", busy, 0);
        repeat (3) @(posedge clk);
        #1 chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic load_and_check(input logic [31:0] b, input logic m);
        int unsigned w0 = wr_cnt, d0 = done_cnt;
        log_q.delete();
        start_load(b, m);
        wait_done(d0, 2000);
        finish_checks(w0, d0);
    endtask

    initial begin
        int unsigned r0, w0, d0, rel;
        fill = 0; mode = 0; addr = '0; fifo_full = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("rst_addr", mem_addr, 0);
        chk("rst_data", dataByte, 0);
        chk("rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        r0 = req_cnt;
        repeat (20) @(posedge clk);
        #1 chk("idle_req", req_cnt - r0, 0);
        chk("idle_busy", busy, 0);

        // row-major from address 0
        load_and_check(32'h0, 1'b0);
        chk("m0_w0_en", log_q[0].en, 9'h001);
        chk("m0_w0_d", log_q[0].d, 8'h00);
        chk("m0_w7_en", log_q[7].en, 9'h001);
        chk("m0_w8_en", log_q[8].en, 9'h002);
        chk("m0_w8_d", log_q[8].d, 8'h08);
        chk("m0_w71_en", log_q[71].en, 9'h100);
        chk("m0_w71_d", log_q[71].d, 8'h47);

        // interleaved from 0x10
        load_and_check(32'h10, 1'b1);
        chk("m1_w0_en", log_q[0].en, 9'h001);
        chk("m1_w0_d", log_q[0].d, 8'h10);
        chk("m1_w1_en", log_q[1].en, 9'h002);
        chk("m1_w1_d", log_q[1].d, 8'h11);
        chk("m1_w9_en", log_q[9].en, 9'h001);
        chk("m1_w9_d", log_q[9].d, 8'h19);

        // FIFO0 full through the first write: REQ, WAIT, then 10 stalled WRITE cycles
        w0 = wr_cnt; d0 = done_cnt; r0 = req_cnt;
        log_q.delete();
        fifo_full = 9'h001;
        start_load(32'h0, 1'b0);
        repeat (12) @(posedge clk);
        #1 chk("stall_no_write", wr_cnt - w0, 0);
        chk("stall_one_req", req_cnt - r0, 1);
        chk("stall_busy", busy, 1);
        fifo_full = '0;
        rel = cyc;
        wait_done(d0, 2000);
        chk("stall_release_cyc", log_q[0].cyc, rel);
        chk("stall_release_en", log_q[0].en, 9'h001);
        finish_checks(w0, d0);

        // random latency and backpressure, address wrap, ignored fills mid-load
        rand_lat = 1; rand_full = 1;
        w0 = wr_cnt; d0 = done_cnt;
        log_q.delete();
        start_load(32'hFFFF_FFF0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            repeat (20 + 30 * i) @(posedge clk);
            #1 fill = 1'b1; addr = 32'h1234_0000 + i; mode = 1'b0;
            @(posedge clk);
            #1 fill = 1'b0;
        end
        wait_done(d0, 5000);
        rand_full = 0;
        fifo_full = '0;
        chk("wrap_w15_d", log_q[15].d, 8'hFF);
        chk("wrap_w16_d", log_q[16].d, 8'h00);
        chk("wrap_w16_en", log_q[16].en, 9'h080);
        finish_checks(w0, d0);
        chk("no_err", err, 0);

        // asynchronous reset mid-load
        start_load(32'h40, 1'b0);
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("mid_rst_req", mem_rd_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_data", dataByte, 0);
        chk("mid_rst_en", fifoEnable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        exp_q.delete(); exp_addr_q.delete();
        rand_lat = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("post_rst_busy", busy, 0);

`ifdef LOADER_TIMEOUT_EN
        never = 1; allow_abort = 1;
        w0 = wr_cnt; d0 = done_cnt;
        start_load(32'h80, 1'b0);
        wait_done(d0, 500);
        chk("to_latency", done_cyc - req_cyc, TO);
        chk("to_err", err, 1);
        chk("to_no_write", wr_cnt - w0, 0);
        repeat (3) @(posedge clk);
        #1 exp_q.delete(); exp_addr_q.delete();
        never = 0; allow_abort = 0;
        load_and_check(32'h0, 1'b0);
        chk("to_err_sticky", err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
